// File: rtl/glitch_cmd_encoder.sv
// Serialises a captured glitch command into a 10-byte UART frame (header, fields, XOR checksum).
// Optional acknowledge/timeout wait after the last byte is enabled by defining GLITCH_CMD_ACK_EN.
module glitch_cmd_encoder #(
    parameter logic [7:0]  HEADER      = 8'hA5,
    parameter logic [7:0]  ACK_BYTE    = 8'hAC,
    parameter int unsigned ACK_TIMEOUT = 12000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_opcode,
    input  logic [31:0] cmd_delay,
    input  logic [15:0] cmd_width,
    input  logic [7:0]  cmd_count,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        tx_done,
    input  logic        rx_done,
    input  logic [7:0]  rx_data,
    output logic        busy,
    output logic        done,
    output logic        ack_ok,
    output logic        timeout_err
);

`ifdef GLITCH_CMD_ACK_EN
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_DONE, ACK_WAIT, FINISH} state_t;
    logic [31:0] ack_cnt_q;
`else
    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_DONE, FINISH} state_t;
    logic unused_ok;
    assign unused_ok = &{1'b0, rx_done, rx_data, ACK_BYTE, ACK_TIMEOUT[0]};
`endif

    state_t      state_q;
    logic [7:0]  opcode_q;
    logic [31:0] delay_q;
    logic [15:0] width_q;
    logic [7:0]  count_q;
    logic [3:0]  idx_q;
    logic        tx_start_q;
    logic [7:0]  tx_data_q;
    logic        busy_q;
    logic        done_q;
    logic        cmd_ready_q;
    logic        ack_ok_q;
    logic        timeout_err_q;
    logic [7:0]  checksum;
    logic [7:0]  tx_byte_d;

    assign checksum = opcode_q ^ delay_q[31:24] ^ delay_q[23:16] ^ delay_q[15:8]
                    ^ delay_q[7:0] ^ width_q[15:8] ^ width_q[7:0] ^ count_q;

    always_comb begin
        tx_byte_d = 8'h00;
        case (idx_q)
            4'd0:    tx_byte_d = HEADER;
            4'd1:    tx_byte_d = opcode_q;
            4'd2:    tx_byte_d = delay_q[31:24];
            4'd3:    tx_byte_d = delay_q[23:16];
            4'd4:    tx_byte_d = delay_q[15:8];
            4'd5:    tx_byte_d = delay_q[7:0];
            4'd6:    tx_byte_d = width_q[15:8];
            4'd7:    tx_byte_d = width_q[7:0];
            4'd8:    tx_byte_d = count_q;
            4'd9:    tx_byte_d = checksum;
            default: tx_byte_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            opcode_q      <= 8'h00;
            delay_q       <= 32'h0;
            width_q       <= 16'h0;
            count_q       <= 8'h00;
            idx_q         <= 4'd0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cmd_ready_q   <= 1'b1;
            ack_ok_q      <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef GLITCH_CMD_ACK_EN
            ack_cnt_q     <= 32'd0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && cmd_ready_q) begin
                        opcode_q      <= cmd_opcode;
                        delay_q       <= cmd_delay;
                        width_q       <= cmd_width;
                        count_q       <= cmd_count;
                        ack_ok_q      <= 1'b0;
                        timeout_err_q <= 1'b0;
                        busy_q        <= 1'b1;
                        cmd_ready_q   <= 1'b0;
                        idx_q         <= 4'd0;
                        state_q       <= LOAD;
                    end
                end
                LOAD: begin
                    idx_q   <= 4'd0;
                    state_q <= SEND;
                end
                SEND: begin
                    if (!tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= tx_byte_d;
                        state_q    <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    // A done coincident with our own start strobe cannot belong to this byte.
                    if (tx_done && !tx_start_q) begin
                        if (idx_q == 4'd9) begin
`ifdef GLITCH_CMD_ACK_EN
                            ack_cnt_q <= 32'd0;
                            state_q   <= ACK_WAIT;
`else
                            done_q    <= 1'b1;
                            state_q   <= FINISH;
`endif
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= SEND;
                        end
                    end
                end
`ifdef GLITCH_CMD_ACK_EN
                ACK_WAIT: begin
                    if (rx_done && (rx_data == ACK_BYTE)) begin
                        ack_ok_q <= 1'b1;
                        done_q   <= 1'b1;
                        state_q  <= FINISH;
                    end else if (ack_cnt_q == ACK_TIMEOUT - 1) begin
                        timeout_err_q <= 1'b1;
                        done_q        <= 1'b1;
                        state_q       <= FINISH;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 32'd1;
                    end
                end
`endif
                FINISH: begin
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    busy_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_ok      = ack_ok_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_glitch_cmd_encoder.sv
// Directed bench for glitch_cmd_encoder with a 5-cycle UART transmitter model.
// Acknowledge scenarios run only when GLITCH_CMD_ACK_EN is defined.
module tb_glitch_cmd_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode = 8'h00;
    logic [31:0] cmd_delay = 32'h0;
    logic [15:0] cmd_width = 16'h0;
    logic [7:0]  cmd_count = 8'h00;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        tx_busy_m = 1'b0;
    logic        tx_busy_hold = 1'b0;
    logic        tx_done = 1'b0;
    logic        rx_done = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        busy;
    logic        done;
    logic        ack_ok;
    logic        timeout_err;

    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          extra_starts = 0;
    int          unstable = 0;
    bit          chk_stable = 1'b1;
    logic [7:0]  frame_q[$];
    logic [7:0]  exp_b[10];

    assign tx_busy = tx_busy_m | tx_busy_hold;

    glitch_cmd_encoder #(
        .HEADER      (8'hA5),
        .ACK_BYTE    (8'hAC),
        .ACK_TIMEOUT (100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_opcode  (cmd_opcode),
        .cmd_delay   (cmd_delay),
        .cmd_width   (cmd_width),
        .cmd_count   (cmd_count),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .rx_done     (rx_done),
        .rx_data     (rx_data),
        .busy        (busy),
        .done        (done),
        .ack_ok      (ack_ok),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, expv);
        end
    endtask

    // Transmitter model: accepts a start, stays busy, pulses tx_done 5 cycles later.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (tx_start) begin
                frame_q.push_back(tx_data);
                tx_busy_m = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(posedge clk); #1;
                    if (tx_start) extra_starts++;
                    if (chk_stable && (tx_data !== frame_q[$])) unstable++;
                end
                tx_done = 1'b1;
                @(posedge clk); #1;
                tx_done   = 1'b0;
                tx_busy_m = 1'b0;
            end
        end
    end

    task automatic load_exp(input logic [79:0] v);
        for (int i = 0; i < 10; i++) exp_b[i] = v[79-8*i -: 8];
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] d,
                            input logic [15:0] w, input logic [7:0] c);
        bit sent;
        sent = 1'b0;
        for (int i = 0; i < 100 && !sent; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                cmd_opcode = op; cmd_delay = d; cmd_width = w; cmd_count = c;
                cmd_valid  = 1'b1;
                @(negedge clk);
                cmd_valid  = 1'b0;
                sent       = 1'b1;
            end
        end
        chk("cmd_accepted", {31'd0, sent}, 32'd1);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk({tag, "_done"}, {31'd0, seen}, 32'd1);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
        chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_idle_ready"}, {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_len"}, frame_q.size(), 32'd10);
        for (int i = 0; i < 10 && i < frame_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {24'd0, frame_q[i]}, {24'd0, exp_b[i]});
        chk({tag, "_extra_start"}, extra_starts, 32'd0);
        chk({tag, "_tx_data_stable"}, unstable, 32'd0);
    endtask

    task automatic wait_last_done(input string tag, output int c0);
        bit seen;
        seen = 1'b0;
        c0   = 0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (frame_q.size() == 10 && tx_done) begin
                seen = 1'b1;
                c0   = cyc;
            end
        end
        chk({tag, "_last_txdone"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        int c0;
        bit got;
        repeat (3) @(negedge clk);
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ack_ok", {31'd0, ack_ok}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        rst = 1'b0;

        // Basic frame: XOR of 01 00 00 12 34 00 10 03 is 0x34.
        load_exp(80'hA5_01_00_00_12_34_00_10_03_34);
        frame_q.delete();
        send_cmd(8'h01, 32'h0000_1234, 16'h0010, 8'h03);
        wait_done("t1", 1500);
        check_frame("t1");
`ifndef GLITCH_CMD_ACK_EN
        chk("t1_ack_ok", {31'd0, ack_ok}, 32'd0);
        chk("t1_timeout", {31'd0, timeout_err}, 32'd0);
        @(negedge clk); rx_data = 8'hAC; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
        chk("t1_rx_ignored_ack", {31'd0, ack_ok}, 32'd0);
        chk("t1_rx_ignored_busy", {31'd0, busy}, 32'd0);
`endif

        // Back-pressure before byte 3 plus a foreign command pulsed mid-frame.
        load_exp(80'hA5_5A_DE_AD_BE_EF_01_02_FF_84);
        frame_q.delete();
        fork
            begin
                got = 1'b0;
                for (int i = 0; i < 500 && !got; i++) begin
                    @(negedge clk);
                    if (frame_q.size() == 2 && tx_done) got = 1'b1;
                end
                chk("t2_hold_arm", {31'd0, got}, 32'd1);
                tx_busy_hold = 1'b1;
                repeat (20) @(negedge clk);
                chk("t2_no_start_in_hold", frame_q.size(), 32'd2);
                tx_busy_hold = 1'b0;
            end
            begin
                for (int i = 0; i < 1000 && frame_q.size() < 5; i++) @(negedge clk);
                chk("t2_intruder_ready", {31'd0, cmd_ready}, 32'd0);
                cmd_opcode = 8'hFF; cmd_delay = 32'hFFFF_FFFF;
                cmd_width  = 16'hFFFF; cmd_count = 8'hFF;
                cmd_valid  = 1'b1;
                @(negedge clk);
                cmd_valid  = 1'b0;
            end
            begin
                send_cmd(8'h5A, 32'hDEAD_BEEF, 16'h0102, 8'hFF);
                wait_done("t2", 2000);
            end
        join
        check_frame("t2");

        // Reset after the fourth byte has started.
        load_exp(80'hA5_01_00_00_12_34_00_10_03_34);
        frame_q.delete();
        send_cmd(8'h01, 32'h0000_1234, 16'h0010, 8'h03);
        for (int i = 0; i < 500 && frame_q.size() < 4; i++) @(negedge clk);
        chk("t3_reached_b4", frame_q.size(), 32'd4);
        chk_stable = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t3_busy", {31'd0, busy}, 32'd0);
        chk("t3_ready", {31'd0, cmd_ready}, 32'd1);
        chk("t3_tx_start", {31'd0, tx_start}, 32'd0);
        repeat (40) @(negedge clk);
        chk("t3_no_more_bytes", frame_q.size(), 32'd4);
        chk_stable = 1'b1;
        // 80 00 00 00 01 80 00 00 XORs to 0x01.
        load_exp(80'hA5_80_00_00_00_01_80_00_00_01);
        frame_q.delete();
        send_cmd(8'h80, 32'h0000_0001, 16'h8000, 8'h00);
        wait_done("t3b", 2000);
        check_frame("t3b");

`ifdef GLITCH_CMD_ACK_EN
        // Non-matching byte is dropped, then the acknowledge completes the frame.
        load_exp(80'hA5_01_00_00_12_34_00_10_03_34);
        frame_q.delete();
        send_cmd(8'h01, 32'h0000_1234, 16'h0010, 8'h03);
        wait_last_done("t4", c0);
        repeat (3) @(negedge clk);
        rx_data = 8'h55; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("t4_55_ignored_ack", {31'd0, ack_ok}, 32'd0);
        chk("t4_55_still_busy", {31'd0, busy}, 32'd1);
        rx_data = 8'hAC; rx_done = 1'b1;
        @(negedge clk); rx_done = 1'b0;
        chk("t4_ack_ok", {31'd0, ack_ok}, 32'd1);
        chk("t4_done_pulse", {31'd0, done}, 32'd1);
        wait_done("t4", 5);
        chk("t4_ack_ok_hold", {31'd0, ack_ok}, 32'd1);
        chk("t4_timeout", {31'd0, timeout_err}, 32'd0);
        check_frame("t4");

        // Silence after the frame: timeout exactly 100 cycles after the last tx_done.
        load_exp(80'hA5_5A_DE_AD_BE_EF_01_02_FF_84);
        frame_q.delete();
        send_cmd(8'h5A, 32'hDEAD_BEEF, 16'h0102, 8'hFF);
        chk("t5_ack_cleared", {31'd0, ack_ok}, 32'd0);
        wait_last_done("t5", c0);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            if (timeout_err) got = 1'b1;
        end
        chk("t5_timeout_seen", {31'd0, got}, 32'd1);
        chk("t5_timeout_latency", cyc - c0 - 1, 32'd100);
        chk("t5_ack_ok", {31'd0, ack_ok}, 32'd0);
        chk("t5_done_pulse", {31'd0, done}, 32'd1);
        wait_done("t5", 5);
        check_frame("t5");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
